// File: rtl/snn_syn_pkg.sv
// snn_syn_pkg: shared state encoding, lane-count derivation and configuration check
package snn_syn_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_RD = 3'd1, S_CAP = 3'd2, S_WR = 3'd3, S_RSP = 3'd4;
  typedef enum logic [2:0] {IDLE = S_IDLE, RD = S_RD, CAP = S_CAP, WR = S_WR, RSP = S_RSP} state_t;
  function automatic int nsyn(input int dw, input int wb);
    return dw / wb;
  endfunction
  function automatic bit cfg_ok(input int dw, input int wb);
    return wb > 0 && dw % wb == 0;
  endfunction
endpackage

// File: rtl/syn_sat_add.sv
// syn_sat_add: unsigned weight plus signed delta, saturated to [0, 2^W_BITS-1]
module syn_sat_add #(
  parameter int W_BITS = 4
) (
  input  logic [W_BITS-1:0] w,
  input  logic [W_BITS-1:0] d,
  output logic [W_BITS-1:0] q
);
  logic signed [W_BITS+1:0] s;
  assign s = $signed({2'b00, w}) + $signed({{2{d[W_BITS-1]}}, d});
  always_comb q = s[W_BITS+1] ? '0 : s[W_BITS] ? '1 : s[W_BITS-1:0];
endmodule

// File: rtl/synaptic_rmw_ctrl.sv
// synaptic_rmw_ctrl: read / read-modify-write controller for a synaptic weight SRAM
module synaptic_rmw_ctrl
  import snn_syn_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int W_BITS     = 4
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WR,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DELTA,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  SRAM_CS,
  output logic                  SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q,
  output logic                  BUSY
);
  localparam int NSYN = nsyn(DATA_WIDTH, W_BITS);
  if (!cfg_ok(DATA_WIDTH, W_BITS)) begin : g_cfg_err
    $error("DATA_WIDTH must be a multiple of W_BITS");
  end
  state_t                state, nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] delta_q, new_q, rsp_q, sum;
  for (genvar i = 0; i < NSYN; i++) begin : g_lane
    syn_sat_add #(.W_BITS(W_BITS)) u_lane (
      .w(SRAM_Q[i*W_BITS +: W_BITS]),
      .d(delta_q[i*W_BITS +: W_BITS]),
      .q(sum[i*W_BITS +: W_BITS])
    );
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = REQ_VALID ? RD : IDLE;
      RD:      nxt = CAP;
      CAP:     nxt = wr_q ? WR : RSP;
      WR:      nxt = RSP;
      default: nxt = IDLE;
    endcase
  end
  // Response data is loaded on the edge entering RSP so it holds between strobes.
  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      delta_q <= '0;
      new_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && REQ_VALID) begin
        addr_q  <= REQ_ADDR;
        wr_q    <= REQ_WR;
        delta_q <= REQ_DELTA;
      end
      if (state == CAP) begin
        new_q <= sum;
        if (!wr_q) rsp_q <= SRAM_Q;
      end
      if (state == WR) rsp_q <= new_q;
    end
  end
  assign REQ_READY = state == IDLE && !RST;
  assign BUSY      = state != IDLE && !RST;
  assign RSP_VALID = state == RSP && !RST;
  assign RSP_DATA  = rsp_q;
  assign SRAM_CS   = (state == RD || state == WR) && !RST;
  assign SRAM_WE   = state == WR && !RST;
  assign SRAM_A    = addr_q;
  assign SRAM_D    = new_q;
endmodule

// File: tb/tb_synaptic_rmw_ctrl.sv
// tb_synaptic_rmw_ctrl: directed bench for synaptic_rmw_ctrl with a behavioural SRAM
module tb_synaptic_rmw_ctrl;
  logic        CK = 0, RST = 1;
  logic        REQ_VALID = 0, REQ_WR = 0;
  logic [7:0]  REQ_ADDR = 0;
  logic [31:0] REQ_DELTA = 0;
  logic        REQ_READY, RSP_VALID, SRAM_CS, SRAM_WE, BUSY;
  logic [31:0] RSP_DATA, SRAM_D, SRAM_Q;
  logic [7:0]  SRAM_A;
  logic [31:0] mem [256];
  logic        pre_en = 0;
  logic [7:0]  pre_a = 0;
  logic [31:0] pre_d = 0;
  int          cyc = 0, cs_n = 0, wr_n = 0, acc_n = 0, rsp_n = 0;
  int          acc_cyc [256];
  int          rsp_cyc [256];
  logic [7:0]  last_rd_a = 0, last_wr_a = 0;
  int          passed = 0, fails = 0, total = 0;

  synaptic_rmw_ctrl dut (
    .CK(CK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_DELTA(REQ_DELTA), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q),
    .BUSY(BUSY)
  );

  always #5 CK = ~CK;

  always @(posedge CK) begin
    cyc <= cyc + 1;
    if (SRAM_CS) begin
      cs_n <= cs_n + 1;
      if (SRAM_WE) begin
        mem[SRAM_A] <= SRAM_D;
        wr_n        <= wr_n + 1;
        last_wr_a   <= SRAM_A;
      end else begin
        SRAM_Q    <= mem[SRAM_A];
        last_rd_a <= SRAM_A;
      end
    end else if (pre_en) mem[pre_a] <= pre_d;
    if (REQ_VALID && REQ_READY) begin
      acc_cyc[acc_n[7:0]] <= cyc;
      acc_n <= acc_n + 1;
    end
    if (RSP_VALID) begin
      rsp_cyc[rsp_n[7:0]] <= cyc;
      rsp_n <= rsp_n + 1;
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_en = 1; pre_a = a; pre_d = d;
    tick();
    pre_en = 0;
  endtask

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] data);
    REQ_VALID = 1; REQ_WR = wr; REQ_ADDR = a; REQ_DELTA = d;
    tick();
    REQ_VALID = 0;
    lat = 1;
    while (!RSP_VALID && lat < 12) begin
      tick();
      lat++;
    end
    data = RSP_DATA;
    tick();
  endtask

  initial begin
    int          lat, got, w0, r0, c0, a0, s0;
    logic [31:0] data, r1, r2;
    preload(8'h05, 32'h12345678);
    preload(8'h10, 32'h0F0F0F02);
    preload(8'h11, 32'h89ABCDEF);
    preload(8'h20, 32'h00000000);
    preload(8'h30, 32'hCAFEBABE);
    preload(8'h31, 32'h00000000);
    preload(8'h40, 32'h33333333);
    preload(8'hFF, 32'hA5A5A5A5);
    chk("rst_ready", 32'(REQ_READY), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_sram_a", 32'(SRAM_A), 0);
    chk("rst_sram_d", SRAM_D, 0);
    chk("rst_cs", 32'(SRAM_CS), 0);
    RST = 0;
    tick();
    chk("idle_ready", 32'(REQ_READY), 1);

    // plain read
    REQ_VALID = 1; REQ_WR = 0; REQ_ADDR = 8'h05; REQ_DELTA = 32'hFFFFFFFF;
    tick();
    REQ_VALID = 0;
    chk("rd_cs", 32'(SRAM_CS), 1);
    chk("rd_we", 32'(SRAM_WE), 0);
    chk("rd_a", 32'(SRAM_A), 32'h05);
    chk("rd_busy", 32'(BUSY), 1);
    chk("rd_ready", 32'(REQ_READY), 0);
    tick();
    chk("cap_cs", 32'(SRAM_CS), 0);
    chk("cap_rsp_valid", 32'(RSP_VALID), 0);
    tick();
    chk("read_rsp_valid", 32'(RSP_VALID), 1);
    chk("read_rsp_data", RSP_DATA, 32'h12345678);
    tick();
    chk("read_rsp_drop", 32'(RSP_VALID), 0);
    chk("read_rsp_hold", RSP_DATA, 32'h12345678);
    chk("read_ready_again", 32'(REQ_READY), 1);
    chk("read_no_write", 32'(wr_n), 0);

    // mixed-lane update
    do_req(1, 8'h10, 32'h1111111B, lat, data);
    chk("mix_latency", 32'(lat), 4);
    chk("mix_rsp", data, 32'h1F1F1F10);
    chk("mix_mem", mem[8'h10], 32'h1F1F1F10);
    chk("mix_wr_count", 32'(wr_n), 1);
    do_req(1, 8'h11, 32'h88888888, lat, data);
    chk("neg8_rsp", data, 32'h01234567);
    do_req(1, 8'h11, 32'h77777777, lat, data);
    chk("pos7_rsp", data, 32'h789ABCDE);
    do_req(1, 8'h11, 32'hFFFFFFFF, lat, data);
    chk("neg1_rsp", data, 32'h6789ABCD);
    chk("neg1_mem", mem[8'h11], 32'h6789ABCD);

    // back-to-back updates with REQ_VALID held
    a0 = acc_n; s0 = rsp_n; got = 0; r1 = 0; r2 = 0;
    REQ_VALID = 1; REQ_WR = 1; REQ_ADDR = 8'h20; REQ_DELTA = 32'h11111111;
    for (int k = 0; k < 30 && got < 2; k++) begin
      tick();
      if (RSP_VALID) begin
        if (got == 0) r1 = RSP_DATA; else r2 = RSP_DATA;
        got++;
        if (got == 2) REQ_VALID = 0;
      end
    end
    REQ_VALID = 0;
    tick();
    chk("b2b_rsp_count", 32'(got), 2);
    chk("b2b_first", r1, 32'h11111111);
    chk("b2b_second", r2, 32'h22222222);
    chk("b2b_accepts", 32'(acc_n - a0), 2);
    chk("b2b_accept_after_rsp", 32'(acc_cyc[a0 + 1]), 32'(rsp_cyc[s0] + 1));
    chk("b2b_mem", mem[8'h20], 32'h22222222);

    // request pulsed while busy is ignored
    c0 = cs_n; w0 = wr_n;
    REQ_VALID = 1; REQ_WR = 0; REQ_ADDR = 8'h30;
    tick();
    REQ_VALID = 0;
    tick();
    REQ_VALID = 1; REQ_WR = 1; REQ_ADDR = 8'h31; REQ_DELTA = 32'h11111111;
    chk("busy_not_ready", 32'(REQ_READY), 0);
    tick();
    REQ_VALID = 0;
    chk("busy_rsp_valid", 32'(RSP_VALID), 1);
    chk("busy_rsp_data", RSP_DATA, 32'hCAFEBABE);
    tick();
    tick();
    chk("busy_one_access", 32'(cs_n - c0), 1);
    chk("busy_no_write", 32'(wr_n - w0), 0);
    chk("busy_other_mem", mem[8'h31], 0);

    // reset asserted during the write cycle
    w0 = wr_n; r0 = rsp_n;
    REQ_VALID = 1; REQ_WR = 1; REQ_ADDR = 8'h40; REQ_DELTA = 32'h11111111;
    tick();
    REQ_VALID = 0;
    tick();
    tick();
    chk("wr_we_before_rst", 32'(SRAM_WE), 1);
    RST = 1;
    #1;
    chk("rst_we_gated", 32'(SRAM_WE), 0);
    chk("rst_cs_gated", 32'(SRAM_CS), 0);
    chk("rst_busy_low", 32'(BUSY), 0);
    chk("rst_ready_low", 32'(REQ_READY), 0);
    tick();
    RST = 0;
    tick();
    chk("rst_ready_after", 32'(REQ_READY), 1);
    tick();
    tick();
    chk("rst_mem_kept", mem[8'h40], 32'h33333333);
    chk("rst_no_write", 32'(wr_n - w0), 0);
    chk("rst_no_rsp", 32'(rsp_n - r0), 0);

    // top address with zero delta
    w0 = wr_n;
    do_req(1, 8'hFF, 32'h0, lat, data);
    chk("edge_latency", 32'(lat), 4);
    chk("edge_rsp", data, 32'hA5A5A5A5);
    chk("edge_mem", mem[8'hFF], 32'hA5A5A5A5);
    chk("edge_rd_a", 32'(last_rd_a), 32'hFF);
    chk("edge_wr_a", 32'(last_wr_a), 32'hFF);
    chk("edge_wr_count", 32'(wr_n - w0), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
